// File: rtl/nios_led_fader_pkg.sv
// rtl/nios_led_fader_pkg.sv - channel state type and duty helpers for the LED fader
// Shared by nios_led_fader and nios_led_fade_chan.
package nios_led_fader_pkg;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RISE = 2'd1,
    CH_ON   = 2'd2,
    CH_FALL = 2'd3
  } chan_state_t;

  function automatic int unsigned duty_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Operands are 32 bits wide, far wider than any duty, so the add never wraps.
  function automatic int unsigned sat_step(input int unsigned duty,
                                           input int unsigned step,
                                           input int unsigned max,
                                           input logic        up);
    int unsigned res;
    if (up) begin
      res = (duty + step > max) ? max : duty + step;
    end else begin
      res = (duty < step) ? 32'd0 : duty - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/nios_led_fade_chan.sv
// rtl/nios_led_fade_chan.sv - one LED channel: OFF/RISE/ON/FALL FSM, duty ramp, PWM compare
// Optional gamma-2 duty curve under `define LED_FADER_GAMMA_EN.
module nios_led_fade_chan
  import nios_led_fader_pkg::*;
#(
  parameter int unsigned PWM_W = 8,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             target,
  input  logic             fade_tick,
  input  logic             enable,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led,
  output logic             in_fade
);

  localparam int unsigned      MAX   = duty_max(PWM_W);
  localparam logic [PWM_W-1:0] MAX_D = PWM_W'(MAX);

  chan_state_t      state, state_n;
  logic [PWM_W-1:0] duty, duty_n, duty_eff;
  logic             led_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CH_OFF;
      duty  <= '0;
      led   <= 1'b0;
    end else begin
      state <= state_n;
      duty  <= duty_n;
      led   <= led_n;
    end
  end

  // Direction changes first, then a coincident tick steps in the new direction.
  always_comb begin
    state_n = state;
    duty_n  = duty;
    if (!enable) begin
      state_n = target ? CH_ON : CH_OFF;
      duty_n  = target ? MAX_D : '0;
    end else begin
      case (state)
        CH_OFF:  if (target)  state_n = CH_RISE;
        CH_RISE: if (!target) state_n = CH_FALL;
        CH_ON:   if (!target) state_n = CH_FALL;
        CH_FALL: if (target)  state_n = CH_RISE;
        default: state_n = CH_OFF;
      endcase
      if (fade_tick && (state_n == CH_RISE || state_n == CH_FALL)) begin
        duty_n = PWM_W'(sat_step(32'(duty), STEP, MAX, state_n == CH_RISE));
        if (state_n == CH_RISE && duty_n == MAX_D) begin
          state_n = CH_ON;
        end else if (state_n == CH_FALL && duty_n == '0) begin
          state_n = CH_OFF;
        end
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_W-1:0] duty_sq;
  assign duty_sq  = {{PWM_W{1'b0}}, duty} * {{PWM_W{1'b0}}, duty};
  assign duty_eff = duty_sq[2*PWM_W-1:PWM_W];
`else
  assign duty_eff = duty;
`endif

  always_comb begin
    led_n = 1'b0;
    if (!enable) begin
      led_n = target;
    end else begin
      case (state)
        CH_ON:            led_n = 1'b1;
        CH_RISE, CH_FALL: led_n = (duty_eff > pwm_cnt);
        default:          led_n = 1'b0;
      endcase
    end
  end

  // Taken from the next state so the registered busy lines up with the state register.
  assign in_fade = (state_n == CH_RISE) || (state_n == CH_FALL);

endmodule

// File: rtl/nios_led_fader.sv
// rtl/nios_led_fader.sv - LED PIO fader top: input register, fade prescaler, PWM counter, busy
// Gamma curve option selected by `define LED_FADER_GAMMA_EN (see nios_led_fade_chan).
module nios_led_fader
  import nios_led_fader_pkg::*;
#(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned STEP     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_in,
  input  logic              enable,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam int unsigned       TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [N_LEDS-1:0] led_in_q;
  logic [N_LEDS-1:0] in_fade;
  logic [TICK_W-1:0] tick_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              fade_tick;

  assign fade_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      led_in_q <= '0;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      led_in_q <= led_in;
      tick_cnt <= fade_tick ? '0 : tick_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      busy     <= |in_fade;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    nios_led_fade_chan #(
      .PWM_W (PWM_W),
      .STEP  (STEP)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .target    (led_in_q[i]),
      .fade_tick (fade_tick),
      .enable    (enable),
      .pwm_cnt   (pwm_cnt),
      .led       (led_out[i]),
      .in_fade   (in_fade[i])
    );
  end

endmodule

// File: tb/tb_nios_led_fader.sv
// tb/tb_nios_led_fader.sv - scoreboard bench for nios_led_fader (fast-tick and slow-tick instances)
// Define LED_FADER_GAMMA_EN to check the gamma build.
module tb_nios_led_fader;

  localparam int K_LED  = 0;
  localparam int K_BUSY = 1;
  localparam int K_PWM  = 2;

  typedef struct {
    int         at;
    int         kind;
    logic [8:0] exp;
    string      name;
  } item_t;

  logic       clk = 1'b0;
  logic       reset_a, reset_b;
  logic       enable_a, enable_b;
  logic [7:0] led_in_a, led_in_b;
  logic [7:0] led_out_a, led_out_b;
  logic       busy_a, busy_b;

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  item_t sb[$];
  logic  hist_b [0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nios_led_fader #(.N_LEDS(8), .PWM_W(8), .TICK_DIV(4), .STEP(64)) dut_a (
    .clk     (clk),
    .reset   (reset_a),
    .led_in  (led_in_a),
    .enable  (enable_a),
    .led_out (led_out_a),
    .busy    (busy_a)
  );

  // Slow ticks hold each duty for 1000 cycles so a full PWM period can be counted.
  nios_led_fader #(.N_LEDS(8), .PWM_W(8), .TICK_DIV(1000), .STEP(64)) dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .led_in  (led_in_b),
    .enable  (enable_b),
    .led_out (led_out_b),
    .busy    (busy_b)
  );

  task automatic expect_at(input int at, input int kind, input logic [8:0] val, input string nm);
    item_t it;
    it.at = at; it.kind = kind; it.exp = val; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin : monitor
    item_t      it;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      hist_b[cyc] = led_out_b[0];
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        it = sb.pop_front();
        act = '0;
        case (it.kind)
          K_LED:  act = {1'b0, led_out_a};
          K_BUSY: act = {8'd0, busy_a};
          default: begin
            for (int i = cyc - 255; i <= cyc; i++) act = act + 9'(hist_b[i]);
          end
        endcase
        n_cmp++;
        if (it.at != cyc || act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: cycle %0d got 0x%0h, expected 0x%0h at cycle %0d",
                   it.name, cyc, act, it.exp, it.at);
        end
      end
    end
  end

  initial begin : stimulus
    logic [8:0] exp64, exp128;
`ifdef LED_FADER_GAMMA_EN
    exp64 = 9'd16; exp128 = 9'd64;
`else
    exp64 = 9'd64; exp128 = 9'd128;
`endif
    reset_a = 1'b1; reset_b = 1'b1;
    enable_a = 1'b1; enable_b = 1'b1;
    led_in_a = 8'hFF; led_in_b = 8'h01;
    expect_at(4, K_LED,  9'h00, "reset_led");
    expect_at(4, K_BUSY, 9'h0,  "reset_busy");

    wait_cyc(4);
    reset_a = 1'b0; reset_b = 1'b0;
    expect_at(5,  K_BUSY, 9'h0,  "busy_release_lat");
    expect_at(6,  K_BUSY, 9'h1,  "busy_after_release");
    expect_at(7,  K_LED,  9'h00, "rise_duty0");
    expect_at(10, K_LED,  9'hFF, "rise_duty64");
    expect_at(19, K_BUSY, 9'h1,  "rise_busy_last");
    expect_at(20, K_BUSY, 9'h0,  "on_busy");
    expect_at(21, K_LED,  9'hFF, "on_led");
    expect_at(30, K_LED,  9'hFF, "on_steady");

    wait_cyc(30);
    led_in_a = 8'h00;
    expect_at(32, K_BUSY, 9'h1,  "fall_busy");
    expect_at(33, K_LED,  9'hFF, "fall_duty191");
    expect_at(43, K_BUSY, 9'h1,  "fall_busy_last");
    expect_at(44, K_BUSY, 9'h0,  "fall_done");
    expect_at(45, K_LED,  9'h00, "off_led");

    wait_cyc(50);
    led_in_a = 8'h01;
    expect_at(53, K_BUSY, 9'h1, "rev_rise_busy");

    wait_cyc(56);
    led_in_a = 8'h00;
    expect_at(59, K_LED,  9'h01, "rev_fall_128");
    expect_at(63, K_BUSY, 9'h1,  "rev_busy_64");
    expect_at(64, K_BUSY, 9'h0,  "rev_off_busy");
    expect_at(65, K_LED,  9'h00, "rev_off_led");
    expect_at(66, K_LED,  9'h00, "rev_stays_off");

    wait_cyc(70);
    enable_a = 1'b0;
    led_in_a = 8'hA5;
    expect_at(71, K_LED,  9'h00, "byp_latency");
    expect_at(72, K_LED,  9'hA5, "byp_led");
    expect_at(72, K_BUSY, 9'h0,  "byp_busy");

    wait_cyc(80);
    enable_a = 1'b1;
    expect_at(85, K_LED,  9'hA5, "reenable_hold");
    expect_at(85, K_BUSY, 9'h0,  "reenable_busy");

    wait_cyc(90);
    led_in_a = 8'h00;
    expect_at(93,  K_LED,  9'hA5, "byp_fall_191");
    expect_at(93,  K_BUSY, 9'h1,  "byp_fall_busy");
    expect_at(98,  K_LED,  9'hA5, "byp_fall_127");
    expect_at(103, K_LED,  9'h00, "byp_fall_63");
    expect_at(104, K_BUSY, 9'h0,  "byp_fall_done");
    expect_at(105, K_LED,  9'h00, "byp_off_led");

    wait_cyc(110);
    led_in_a = 8'hFF;
    expect_at(114, K_BUSY, 9'h1, "pre_reset_busy");

    wait_cyc(115);
    reset_a = 1'b1;
    expect_at(116, K_LED,  9'h00, "midreset_led");
    expect_at(116, K_BUSY, 9'h0,  "midreset_busy");

    wait_cyc(118);
    reset_a = 1'b0;
    expect_at(1265, K_PWM, exp64,  "pwm_duty64");
    expect_at(2265, K_PWM, exp128, "pwm_duty128");

    wait_cyc(2270);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d items pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
